// File: rtl/dc_blocker_mc.sv
// Time-multiplexed multi-channel DC-blocking high-pass filter, one channel per clock, sticky saturation flags.
// Define SOFT_MUTE_EN for a per-frame soft-mute attenuation ramp; otherwise mute hard-zeroes the output slots.
module dc_blocker_mc #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16,
  parameter int FRAC     = 23,
  parameter int K_BASE   = 10
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      sample_rate_i,
  input  logic                      mute_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [CHANNELS*WIDTH-1:0] din_i,
  output logic                      out_valid_o,
  output logic [CHANNELS*WIDTH-1:0] dout_o,
  output logic [CHANNELS-1:0]       sat_o,
  input  logic                      sat_clr_i
);
  localparam int AW = WIDTH + FRAC + 1;
  localparam int EW = AW + 2;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int KW = $clog2(K_BASE + 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PROC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic signed [AW-1:0] Y_MAX = {2'b00, {(WIDTH+FRAC-1){1'b1}}};
  localparam logic signed [AW-1:0] Y_MIN = {2'b11, {(WIDTH+FRAC-1){1'b0}}};

  logic [1:0]                state_q, state_d;
  logic [CW-1:0]             ch_q, ch_d;
  logic [CHANNELS*WIDTH-1:0] din_q;
  logic [KW-1:0]             k_q;
  logic [CHANNELS*WIDTH-1:0] stage_q;
  logic [CHANNELS*WIDTH-1:0] frame_d;
  logic [CHANNELS*WIDTH-1:0] dout_q;
  logic [CHANNELS-1:0]       sat_q, sat_d;
  logic signed [AW-1:0]      x_prev_q [CHANNELS];
  logic signed [AW-1:0]      y_prev_q [CHANNELS];

  logic                      accept;
  logic                      proc;
  logic                      last_ch;
  logic                      clamp;
  logic [WIDTH-1:0]          din_sel;
  logic signed [AW-1:0]      x_cur;
  logic signed [AW-1:0]      xp_cur;
  logic signed [AW-1:0]      yp_cur;
  logic signed [AW-1:0]      yp_shr;
  logic signed [EW-1:0]      y_full;
  logic signed [AW-1:0]      y_clamped;
  logic signed [WIDTH-1:0]   smp_trunc;
  logic signed [WIDTH-1:0]   smp_out;

`ifdef SOFT_MUTE_EN
  logic [4:0]                att_q, att_d;
`else
  logic                      mute_q;
`endif

  assign accept      = (state_q == S_IDLE) && in_valid_i;
  assign proc        = (state_q == S_PROC);
  assign last_ch     = (ch_q == CW'(CHANNELS - 1));
  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign dout_o      = dout_q;
  assign sat_o       = sat_q;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          state_d = S_PROC;
          ch_d    = '0;
        end
      end
      S_PROC: begin
        if (last_ch) state_d = S_DONE;
        else         ch_d    = ch_q + CW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    din_sel = '0;
    xp_cur  = '0;
    yp_cur  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_q == CW'(c)) begin
        din_sel = din_q[c*WIDTH +: WIDTH];
        xp_cur  = x_prev_q[c];
        yp_cur  = y_prev_q[c];
      end
    end
  end

  // Two guard bits above AW absorb x - x_prev + y_prev before the clamp
  always_comb begin
    x_cur  = {din_sel[WIDTH-1], din_sel, {FRAC{1'b0}}};
    yp_shr = yp_cur >>> k_q;
    y_full = EW'(x_cur) - EW'(xp_cur) + EW'(yp_cur) - EW'(yp_shr);
    clamp  = 1'b1;
    if (y_full > EW'(Y_MAX))      y_clamped = Y_MAX;
    else if (y_full < EW'(Y_MIN)) y_clamped = Y_MIN;
    else begin
      y_clamped = y_full[AW-1:0];
      clamp     = 1'b0;
    end
    smp_trunc = y_clamped[WIDTH+FRAC-1:FRAC];
  end

`ifdef SOFT_MUTE_EN
  always_comb begin
    if (att_q >= 5'(WIDTH)) smp_out = '0;
    else                    smp_out = smp_trunc >>> att_q;
  end

  always_comb begin
    att_d = att_q;
    if (accept) begin
      if (mute_i) begin
        if (att_q != 5'(WIDTH)) att_d = att_q + 5'd1;
      end else if (att_q != 5'd0) begin
        att_d = att_q - 5'd1;
      end
    end
  end
`else
  always_comb begin
    if (mute_q) smp_out = '0;
    else        smp_out = smp_trunc;
  end
`endif

  always_comb begin
    frame_d = stage_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_q == CW'(c)) frame_d[c*WIDTH +: WIDTH] = smp_out;
    end
  end

  // A new saturation event beats a simultaneous clear
  always_comb begin
    sat_d = sat_clr_i ? '0 : sat_q;
    if (proc && clamp) sat_d[ch_q] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      din_q   <= '0;
      k_q     <= '0;
      stage_q <= '0;
      dout_q  <= '0;
      sat_q   <= '0;
`ifdef SOFT_MUTE_EN
      att_q   <= '0;
`else
      mute_q  <= 1'b0;
`endif
      for (int c = 0; c < CHANNELS; c++) begin
        x_prev_q[c] <= '0;
        y_prev_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      sat_q   <= sat_d;
`ifdef SOFT_MUTE_EN
      att_q   <= att_d;
`endif
      if (accept) begin
        din_q  <= din_i;
        k_q    <= KW'(K_BASE) + KW'(sample_rate_i);
`ifndef SOFT_MUTE_EN
        mute_q <= mute_i;
`endif
      end
      if (proc) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (ch_q == CW'(c)) begin
            x_prev_q[c] <= x_cur;
            y_prev_q[c] <= y_clamped;
          end
        end
        stage_q <= frame_d;
        // dout only moves when the whole frame is ready, so it holds between strobes
        if (last_ch) dout_q <= frame_d;
      end
    end
  end
endmodule

// File: tb/tb_dc_blocker_mc.sv
// Scoreboard bench for dc_blocker_mc: a 64-bit integer reference model predicts each frame on accept.
module tb_dc_blocker_mc;
  localparam int CH = 2;
  localparam int W  = 16;
  localparam int F  = 23;
  localparam int KB = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_rate = 1'b0;
  logic          mute = 1'b0;
  logic          in_valid = 1'b0;
  logic          sat_clr = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [CH*W-1:0] din = '0;
  logic [CH*W-1:0] dout;
  logic [CH-1:0]   sat;

  dc_blocker_mc #(.CHANNELS(CH), .WIDTH(W), .FRAC(F), .K_BASE(KB)) dut (
    .clk_i(clk), .reset_i(reset), .sample_rate_i(sample_rate), .mute_i(mute),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .din_i(din),
    .out_valid_o(out_valid), .dout_o(dout), .sat_o(sat), .sat_clr_i(sat_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH*W-1:0] dout;
    logic [CH-1:0]   sat;
    int              t;
  } exp_t;

  exp_t   q[$];
  exp_t   mon_e;
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     ov_cnt = 0;
  longint mx[CH];
  longint my[CH];
  int     matt;
  logic [CH-1:0] msat;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      mx[c] = 0;
      my[c] = 0;
    end
    matt = 0;
    msat = '0;
  endtask

  // y = x - x_prev + y_prev - floor(y_prev / 2^K), clamped to the WIDTH-bit range
  task automatic model_accept(input logic [CH*W-1:0] d, input bit mu, input bit sr, input int t);
    exp_t   e;
    int     k;
    int     s;
    longint x;
    longint y;
    longint lim;
    k   = KB + (sr ? 1 : 0);
    lim = longint'(1) <<< (W + F - 1);
`ifdef SOFT_MUTE_EN
    if (mu) matt = (matt < W) ? matt + 1 : W;
    else    matt = (matt > 0) ? matt - 1 : 0;
`endif
    e.dout = '0;
    for (int c = 0; c < CH; c++) begin
      x = longint'($signed(d[c*W +: W])) * (longint'(1) <<< F);
      y = x - mx[c] + my[c] - (my[c] >>> k);
      if (y > lim - 1) begin
        y = lim - 1;
        msat[c] = 1'b1;
      end else if (y < -lim) begin
        y = -lim;
        msat[c] = 1'b1;
      end
      mx[c] = x;
      my[c] = y;
      s = int'(y >>> F);
`ifdef SOFT_MUTE_EN
      s = (matt >= W) ? 0 : (s >>> matt);
`else
      if (mu) s = 0;
`endif
      e.dout[c*W +: W] = s[W-1:0];
    end
    e.sat = msat;
    e.t   = t;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      ov_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: strobe at cycle %0d, required none", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("dout", dout, mon_e.dout);
        chk("sat", sat, mon_e.sat);
        chk("latency", cyc - mon_e.t, CH + 1);
      end
    end
  end

  task automatic send(input logic [CH*W-1:0] d, input bit mu, input bit sr, output int t);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    din = d;
    mute = mu;
    sample_rate = sr;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready 0 for %0d cycles, required 1", n);
    end else begin
      model_accept(d, mu, sr, cyc);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q.size(), 0);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    sat_clr = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int t;
    int tp;
    int n;
    int ovs;
    logic [CH*W-1:0] d;
    logic [W-1:0] s;
    bit mu;

    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_sat", sat, 0);

    // DC step, K = K_BASE
    d = {16'h0000, 16'h4000};
    send(d, 0, 0, t); idle(); drain();
    chk("step_f1_ch0", dout[15:0], 16'h4000);
    chk("step_f1_ch1", dout[31:16], 16'h0000);
    send(d, 0, 0, t); idle(); drain();
    chk("step_f2_ch0", dout[15:0], 16'h3FF0);
    chk("step_f2_ch1", dout[31:16], 16'h0000);

    // DC step, K = K_BASE+1, then streamed decay
    reset_dut();
    send(d, 0, 1, t); idle(); drain();
    send(d, 0, 1, t); idle(); drain();
    chk("step_sr1_f2_ch0", dout[15:0], 16'h3FF8);
    n = 0;
    while ((my[0] >>> F) >= 256 && n < 12000) begin
      send(d, 0, 1, t);
      n++;
    end
    idle(); drain();
    chk("decay_below_0x100", (dout[15:0] < 16'h0100), 1);

    // Saturation and sticky clear
    reset_dut();
    d = {16'h0000, 16'h7FFF};
    send(d, 0, 0, t); idle(); drain();
    d = {16'h0000, 16'h8000};
    send(d, 0, 0, t); idle(); drain();
    chk("sat_out_ch0", dout[15:0], 16'h8000);
    chk("sat_flags", sat, 2'b01);
    @(negedge clk); sat_clr = 1'b1;
    @(negedge clk); sat_clr = 1'b0;
    msat = '0;
    chk("sat_cleared", sat, 2'b00);

    // in_valid held high: one accept every CH+2 cycles
    reset_dut();
    tp = 0;
    for (int i = 0; i < 20; i++) begin
      d = $urandom;
      send(d, 0, 0, t);
      if (i > 0) chk("accept_interval", t - tp, CH + 2);
      tp = t;
    end
    idle(); drain();

    // Reset on the cycle after accept drops the frame
    reset_dut();
    d = {16'h0F0F, 16'h1234};
    send(d, 0, 0, t);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    q.delete();
    ovs = ov_cnt;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    repeat (6) @(negedge clk);
    chk("rst_mid_no_out_valid", ov_cnt - ovs, 0);
    chk("rst_mid_dout", dout, 0);
    chk("rst_mid_sat", sat, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    send(d, 0, 0, t); idle(); drain();
    chk("rst_mid_next_ch0", dout[15:0], 16'h1234);

    // Square wave with mute raised, then dropped
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      s = (i % 2 == 0) ? 16'h2000 : 16'hE000;
      send({s, s}, 0, 0, t); idle(); drain();
    end
    for (int i = 1; i <= 17; i++) begin
      s = (i % 2 == 0) ? 16'h2000 : 16'hE000;
      send({s, s}, 1, 0, t); idle(); drain();
`ifdef SOFT_MUTE_EN
      if (i == 16) chk("softmute_zero", dout, 0);
`else
      if (i == 1) chk("hardmute_zero", dout, 0);
`endif
    end
    for (int i = 0; i < 17; i++) begin
      s = (i % 2 == 0) ? 16'h2000 : 16'hE000;
      send({s, s}, 0, 0, t); idle(); drain();
    end

    // Randomized frames, controls and gaps
    reset_dut();
    for (int i = 0; i < 150; i++) begin
      d = $urandom;
      if ($urandom_range(0, 7) == 0) d = {16'h8000, 16'h7FFF};
      mu = ($urandom_range(0, 3) == 0);
      send(d, mu, 1'($urandom_range(0, 1)), t);
      if ($urandom_range(0, 1) == 1) begin
        idle();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    idle(); drain();
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dc_blocker_mc.md
# dc_blocker_mc

Multi-channel, parametrised DC-blocking high-pass filter for the audio output path, sitting between the channel mixer and the output serialiser. One shared datapath is time-multiplexed across CHANNELS channels, one channel per clock, behind a valid/ready handshake. Adds over the single-channel block:
- per-channel saturation flags;
- a selectable pole shift;
- an optional soft-mute ramp.

## Interface
- CHANNELS, 2: number of audio channels; 1..8.
- WIDTH, 16: sample width, signed two's complement.
- FRAC, 23: fractional guard bits; internal width AW = WIDTH+FRAC+1.
- K_BASE, 10: pole shift when sample_rate=0; K_BASE+1 when sample_rate=1.

Ports:
- clk  in  1  audio clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- sample_rate  in  1  selects pole shift K; sampled on input accept.
- mute  in  1  mutes output (hard or ramped, see Configuration).
- in_valid  in  1  input frame valid.
- in_ready  out  1  block can accept a frame.
- din  in  CHANNELS*WIDTH  packed samples, channel 0 in LSBs.
- out_valid  out  1  one-cycle strobe, dout updated.
- dout  out  CHANNELS*WIDTH  filtered samples, held between strobes.
- sat  out  CHANNELS  sticky per-channel saturation flags.
- sat_clr  in  1  clears all sat bits.

## Operation
- Per channel c, fixed point with FRAC fraction bits, x = {din_c, FRAC zeros} sign-extended to AW:
  - y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> K).
  - The right shift is arithmetic.
- Per-channel state registers x_prev[c] and y_prev[c], AW bits each. Both are cleared to 0 on reset.
- Saturation:
  - Clamp y[n] to [-2^(WIDTH-1), 2^(WIDTH-1) - 2^-FRAC].
  - Store the clamped value into y_prev[c].
  - Set sat[c] when clamping occurs.
- Output sample = y_prev[c][WIDTH+FRAC-1:FRAC], truncated, after the mute stage.
- FSM:
  - IDLE: in_ready=1. On in_valid, latch din and K, set ch=0, go to PROC.
  - PROC: compute channel ch and write x_prev, y_prev and the dout slot. If ch=CHANNELS-1 go to DONE, else ch+1.
  - DONE: out_valid=1 for this cycle only, then go to IDLE.
- in_ready is 0 in PROC and DONE. in_valid in those states is ignored; it is not queued.
- sat_clr on the same cycle as a new saturation: the set wins.
- Reset mid-frame: FSM returns to IDLE, the frame is dropped, and no out_valid is produced.

## Timing
- Reset values: in_ready=1, out_valid=0, dout=0, sat=0, all channel state 0, mute attenuation 0.
- Accept cycle T (in_valid & in_ready): PROC occupies T+1..T+CHANNELS, DONE at T+CHANNELS+1.
- out_valid is high on cycle T+CHANNELS+1, and dout is valid from that cycle.
- Throughput: one frame per CHANNELS+2 cycles.
- in_ready returns high on cycle T+CHANNELS+2.
- mute and sample_rate changes take effect at the next accepted frame.

## Configuration
- SOFT_MUTE_EN defined:
  - 5-bit attenuation counter att, range 0..WIDTH.
  - Each accepted frame, att increments by 1 while mute=1 and decrements by 1 while mute=0, saturating at the ends.
  - Output sample = truncated sample >>> att; att=WIDTH forces 0.
  - Zero-crossing-free ramp over WIDTH frames.
- SOFT_MUTE_EN undefined:
  - mute=1 forces dout slots to 0 for frames processed while it is set.
  - Filter state still updates, so unmute is click-free.

## Test plan
- Reset, then CHANNELS=2, K_BASE=10, sample_rate=0, din ch0=0x4000, ch1=0 held -> first frame dout ch0=0x4000; second frame 0x3FF0; ch1 stays 0; out_valid exactly 3 cycles after each accept.
- Same step with sample_rate=1 -> second frame ch0=0x3FF8; decay toward 0, reaching <0x0100 in a bounded number of frames checked against the reference model.
- ch0 sequence 0x7FFF then 0x8000 -> second output 0x8000, sat[0]=1, sat[1]=0; assert sat_clr -> sat=0.
- in_valid held high continuously -> accepts exactly every 4 cycles; no frame is lost or duplicated.
- Reset asserted on the cycle after accept -> no out_valid; dout=0; next frame processed from zero state.
- SOFT_MUTE_EN defined, DC-free square wave 0x2000, mute raised -> output halves each frame and is 0 after 16 frames; mute dropped -> restores over 16 frames. Without SOFT_MUTE_EN -> 0 on the next frame.
